// File: rtl/switch_allocator.sv
// Switch allocator: per-output-port FREE/BUSY ownership with round-robin
// grant, stall teardown, and a round-robin arbiter for the shared
// register bank. Grants are combinational and ownership is registered.
module switch_allocator #(
    parameter int NUM_BUFFERS  = 4,
    parameter int NUM_OUTPORTS = 4,
    parameter int STALL_LIMIT  = 16,
    localparam int PORT_W = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
    localparam int BUF_W  = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1,
    localparam int CNT_W  = $clog2(STALL_LIMIT + 1)
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [NUM_BUFFERS-1:0]          req_pipeline,
    input  logic [NUM_BUFFERS*PORT_W-1:0]   req_outport,
    input  logic [NUM_BUFFERS-1:0]          req_regbank,
    input  logic [NUM_BUFFERS-1:0]          pkt_done,
    input  logic [NUM_OUTPORTS-1:0]         outport_ready,
    output logic [NUM_BUFFERS-1:0]          pipeline_granted,
    output logic [NUM_BUFFERS-1:0]          pipeline_failed,
    output logic [NUM_BUFFERS-1:0]          reg_bank_granted,
    output logic [NUM_OUTPORTS-1:0]         outport_busy,
    output logic [NUM_OUTPORTS*BUF_W-1:0]   outport_owner
);

    typedef enum logic {FREE, BUSY} port_state_e;

    port_state_e      state_q [NUM_OUTPORTS];
    port_state_e      state_d [NUM_OUTPORTS];
    logic [BUF_W-1:0] owner_q [NUM_OUTPORTS];
    logic [BUF_W-1:0] owner_d [NUM_OUTPORTS];
    logic [BUF_W-1:0] rr_q    [NUM_OUTPORTS];
    logic [BUF_W-1:0] rr_d    [NUM_OUTPORTS];
    logic [CNT_W-1:0] cnt_q   [NUM_OUTPORTS];
    logic [CNT_W-1:0] cnt_d   [NUM_OUTPORTS];
    logic [BUF_W-1:0] rb_ptr_q, rb_ptr_d;

    logic [NUM_BUFFERS-1:0] owns_port;
    logic [NUM_BUFFERS-1:0] eligible;
    logic [NUM_BUFFERS-1:0] gnt_c, fail_c, rb_gnt_c;
    logic                   found, rb_found;
    logic [BUF_W-1:0]       win, rb_win;
    int                     idx, rb_idx;

    // Which buffers currently hold a port; they may not request another.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        owns_port = '0;
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            if (state_q[p] == BUSY) owns_port[owner_q[p]] = 1'b1;
        end
    end

    // A register bank request masks the pipeline request on the same buffer.
    assign eligible = req_pipeline & ~req_regbank & ~owns_port;

    // Per-port FSM next state: round-robin grant, release, stall teardown.
    always_comb begin
        gnt_c  = '0;
        fail_c = '0;
        found  = 1'b0;
        win    = '0;
        idx    = 0;
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            state_d[p] = state_q[p];
            owner_d[p] = owner_q[p];
            rr_d[p]    = rr_q[p];
            cnt_d[p]   = cnt_q[p];
        end
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            if (state_q[p] == FREE) begin
                cnt_d[p] = '0;
                found    = 1'b0;
                win      = '0;
                if (outport_ready[p]) begin
                    for (int i = 0; i < NUM_BUFFERS; i++) begin
                        idx = int'(rr_q[p]) + i;
                        if (idx >= NUM_BUFFERS) idx = idx - NUM_BUFFERS;
                        if (!found && eligible[idx] &&
                            req_outport[idx*PORT_W +: PORT_W] == PORT_W'(p)) begin
                            found = 1'b1;
                            win   = BUF_W'(idx);
                        end
                    end
                    if (found) begin
                        gnt_c[win] = 1'b1;
                        state_d[p] = BUSY;
                        owner_d[p] = win;
                        rr_d[p]    = (win == BUF_W'(NUM_BUFFERS - 1)) ? '0 : win + BUF_W'(1);
                    end
                end
            end else begin
                if (pkt_done[owner_q[p]]) begin
                    // Packet completion wins over a simultaneous stall timeout.
                    state_d[p] = FREE;
                    owner_d[p] = '0;
                    cnt_d[p]   = '0;
                end else if (cnt_q[p] == CNT_W'(STALL_LIMIT)) begin
                    fail_c[owner_q[p]] = 1'b1;
                    state_d[p] = FREE;
                    owner_d[p] = '0;
                    cnt_d[p]   = '0;
                end else if (outport_ready[p]) begin
                    cnt_d[p] = '0;
                end else if (cnt_q[p] != CNT_W'(STALL_LIMIT)) begin
                    cnt_d[p] = cnt_q[p] + CNT_W'(1);
                end
            end
        end
    end

    // Shared register bank: one round-robin winner per cycle.
    always_comb begin
        rb_gnt_c = '0;
        rb_found = 1'b0;
        rb_win   = '0;
        rb_idx   = 0;
        rb_ptr_d = rb_ptr_q;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            rb_idx = int'(rb_ptr_q) + i;
            if (rb_idx >= NUM_BUFFERS) rb_idx = rb_idx - NUM_BUFFERS;
            if (!rb_found && req_regbank[rb_idx]) begin
                rb_found = 1'b1;
                rb_win   = BUF_W'(rb_idx);
            end
        end
        if (rb_found) begin
            rb_gnt_c[rb_win] = 1'b1;
            rb_ptr_d = (rb_win == BUF_W'(NUM_BUFFERS - 1)) ? '0 : rb_win + BUF_W'(1);
        end
    end

    // State registers for all port FSMs and both arbiter pointers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: every array entry is reset because owners and pointers
            // must be known immediately after reset; bulk data storage
            // would normally be left unreset.
            for (int p = 0; p < NUM_OUTPORTS; p++) begin
                state_q[p] <= FREE;
                owner_q[p] <= '0;
                rr_q[p]    <= '0;
                cnt_q[p]   <= '0;
            end
            rb_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            for (int p = 0; p < NUM_OUTPORTS; p++) begin
                state_q[p] <= state_d[p];
                owner_q[p] <= owner_d[p];
                rr_q[p]    <= rr_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
            rb_ptr_q <= rb_ptr_d;
        end
    end

    // Pulses are combinational, so hold them low while reset is asserted.
    assign pipeline_granted = nRST ? gnt_c    : '0;
    assign pipeline_failed  = nRST ? fail_c   : '0;
    assign reg_bank_granted = nRST ? rb_gnt_c : '0;

    // Ownership view straight from the registered port state.
    always_comb begin
        outport_busy  = '0;
        outport_owner = '0;
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            outport_busy[p]                  = (state_q[p] == BUSY);
            outport_owner[p*BUF_W +: BUF_W]  = owner_q[p];
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with default parameters. Each step
// pushes its expected outputs to a scoreboard queue when inputs are driven,
// and pops/compares them once the DUT outputs have settled.
module tb_switch_allocator;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [3:0] req_pipeline, req_regbank, pkt_done, outport_ready;
    logic [7:0] req_outport;
    logic [3:0] pipeline_granted, pipeline_failed, reg_bank_granted, outport_busy;
    logic [7:0] outport_owner;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [3:0] fail;
        logic [3:0] rb;
        logic [3:0] busy;
        logic [7:0] owner;
    } exp_t;

    exp_t sb[$];

    switch_allocator dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .req_pipeline     (req_pipeline),
        .req_outport      (req_outport),
        .req_regbank      (req_regbank),
        .pkt_done         (pkt_done),
        .outport_ready    (outport_ready),
        .pipeline_granted (pipeline_granted),
        .pipeline_failed  (pipeline_failed),
        .reg_bank_granted (reg_bank_granted),
        .outport_busy     (outport_busy),
        .outport_owner    (outport_owner)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input string fld,
                         input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
        end
    endtask

    // Inputs are already driven (just after a falling edge); record the
    // expectation, let outputs settle, compare, then move to the next step.
    task automatic cycle(input string tag, input logic [3:0] g, input logic [3:0] f,
                         input logic [3:0] r, input logic [3:0] b, input logic [7:0] o);
        exp_t e;
        e.tag = tag; e.gnt = g; e.fail = f; e.rb = r; e.busy = b; e.owner = o;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check(e.tag, "granted", {4'b0, pipeline_granted}, {4'b0, e.gnt});
        check(e.tag, "failed",  {4'b0, pipeline_failed},  {4'b0, e.fail});
        check(e.tag, "regbank", {4'b0, reg_bank_granted}, {4'b0, e.rb});
        check(e.tag, "busy",    {4'b0, outport_busy},     {4'b0, e.busy});
        check(e.tag, "owner",   outport_owner,            e.owner);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0;
        req_pipeline = '0; req_outport = '0; req_regbank = '0;
        pkt_done = '0; outport_ready = 4'b1111;
        @(negedge CLK);

        // Reset state; a live request must not leak through while in reset.
        req_pipeline = 4'b0001; req_regbank = 4'b0010;
        cycle("reset", 4'b0, 4'b0, 4'b0, 4'b0, 8'h00);
        nRST = 1'b1;
        req_pipeline = '0; req_regbank = '0;
        cycle("idle", 4'b0, 4'b0, 4'b0, 4'b0, 8'h00);

        // Contention on port 1: grants 0, 1, 2, each in the cycle after pkt_done.
        req_outport = 8'h15; req_pipeline = 4'b0111;
        cycle("cont_g0", 4'b0001, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0110; pkt_done = 4'b1000;   // stray done from non-owner
        cycle("cont_hold0", 4'b0, 4'b0, 4'b0, 4'b0010, 8'h00);
        pkt_done = 4'b0001;
        cycle("cont_done0", 4'b0, 4'b0, 4'b0, 4'b0010, 8'h00);
        pkt_done = 4'b0000;
        cycle("cont_g1", 4'b0010, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0100; pkt_done = 4'b0010;
        cycle("cont_done1", 4'b0, 4'b0, 4'b0, 4'b0010, 8'h04);
        pkt_done = 4'b0000;
        cycle("cont_g2", 4'b0100, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0000; pkt_done = 4'b0100;
        cycle("cont_done2", 4'b0, 4'b0, 4'b0, 4'b0010, 8'h08);
        pkt_done = 4'b0000;
        cycle("cont_free", 4'b0, 4'b0, 4'b0, 4'b0000, 8'h00);

        // Not ready: buffer 3 waits on port 0 for five cycles.
        req_outport = 8'h00; req_pipeline = 4'b1000; outport_ready = 4'b1110;
        for (int i = 0; i < 5; i++) cycle("nrdy_wait", 4'b0, 4'b0, 4'b0, 4'b0000, 8'h00);
        outport_ready = 4'b1111;
        cycle("nrdy_g3", 4'b1000, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0000; pkt_done = 4'b1000;
        cycle("nrdy_own", 4'b0, 4'b0, 4'b0, 4'b0001, 8'h03);
        pkt_done = 4'b0000;
        cycle("nrdy_free", 4'b0, 4'b0, 4'b0, 4'b0000, 8'h00);

        // Stall: buffer 1 owns port 2, ready low until teardown.
        req_outport = 8'h08; req_pipeline = 4'b0010;
        cycle("stall_g1", 4'b0010, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0000; outport_ready = 4'b1011;
        for (int i = 0; i < 16; i++) cycle("stall_cnt", 4'b0, 4'b0, 4'b0, 4'b0100, 8'h10);
        cycle("stall_fail", 4'b0, 4'b0010, 4'b0, 4'b0100, 8'h10);
        cycle("stall_free", 4'b0, 4'b0, 4'b0, 4'b0000, 8'h00);
        outport_ready = 4'b1111;

        // Tie: pkt_done lands in the same cycle the stall limit is reached.
        req_outport = 8'h30; req_pipeline = 4'b0100;
        cycle("tie_g2", 4'b0100, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0000; outport_ready = 4'b0111;
        for (int i = 0; i < 16; i++) cycle("tie_cnt", 4'b0, 4'b0, 4'b0, 4'b1000, 8'h80);
        pkt_done = 4'b0100;
        cycle("tie_done", 4'b0, 4'b0, 4'b0, 4'b1000, 8'h80);
        pkt_done = 4'b0000;
        cycle("tie_free", 4'b0, 4'b0, 4'b0, 4'b0000, 8'h00);
        outport_ready = 4'b1111;

        // Register bank fairness; the pipeline request on the same buffers is masked.
        req_outport = 8'h00; req_pipeline = 4'b0101; req_regbank = 4'b0101;
        cycle("rb_0a", 4'b0, 4'b0, 4'b0001, 4'b0000, 8'h00);
        cycle("rb_2a", 4'b0, 4'b0, 4'b0100, 4'b0000, 8'h00);
        cycle("rb_0b", 4'b0, 4'b0, 4'b0001, 4'b0000, 8'h00);
        cycle("rb_2b", 4'b0, 4'b0, 4'b0100, 4'b0000, 8'h00);
        req_pipeline = 4'b0000; req_regbank = 4'b0000;

        // Mid-packet reset with ports 0 and 1 busy.
        req_outport = 8'h04; req_pipeline = 4'b0011;
        cycle("mid_grant", 4'b0011, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0000;
        cycle("mid_busy", 4'b0, 4'b0, 4'b0, 4'b0011, 8'h04);
        nRST = 1'b0;
        req_outport = 8'h28; req_pipeline = 4'b0110; req_regbank = 4'b1000; pkt_done = 4'b0011;
        cycle("mid_rst", 4'b0, 4'b0, 4'b0, 4'b0000, 8'h00);
        nRST = 1'b1; req_regbank = 4'b0000; pkt_done = 4'b0000;
        cycle("post_rst_g1", 4'b0010, 4'b0, 4'b0, 4'b0000, 8'h00);
        req_pipeline = 4'b0000;
        cycle("post_rst_own", 4'b0, 4'b0, 4'b0, 4'b0100, 8'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 4, meaning the number of input buffer requesters.
REQ-002 SHALL have parameter NUM_OUTPORTS, default 4, meaning the number of switch output ports.
REQ-003 SHALL have parameter STALL_LIMIT, default 16, meaning the count of consecutive not-ready cycles before a connection is torn down.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_pipeline, input, NUM_BUFFERS bits: buffer i head flit requests an output connection.
REQ-007 SHALL have port req_outport, input, NUM_BUFFERS x clog2(NUM_OUTPORTS) bits: requested port per buffer, valid with req_pipeline.
REQ-008 SHALL have port req_regbank, input, NUM_BUFFERS bits: buffer i head flit targets the local register bank.
REQ-009 SHALL have port pkt_done, input, NUM_BUFFERS bits: last flit of buffer i's packet read this cycle.
REQ-010 SHALL have port outport_ready, input, NUM_OUTPORTS bits: downstream of port p can accept a flit.
REQ-011 SHALL have port pipeline_granted, output, NUM_BUFFERS bits: one-cycle pulse, connection granted.
REQ-012 SHALL have port pipeline_failed, output, NUM_BUFFERS bits: one-cycle pulse, connection torn down on stall.
REQ-013 SHALL have port reg_bank_granted, output, NUM_BUFFERS bits: one-cycle pulse, register bank access granted.
REQ-014 SHALL have port outport_busy, output, NUM_OUTPORTS bits: port p currently owned.
REQ-015 SHALL have port outport_owner, output, NUM_OUTPORTS x clog2(NUM_BUFFERS) bits: owning buffer index of port p; 0 when free.

Function
REQ-016 SHALL keep one FSM per output port with states FREE and BUSY.
REQ-017 SHALL, in FREE with outport_ready[p] high, grant p to an eligible requester chosen round-robin from pointer rr[p]; eligible means req_pipeline set, req_outport equal to p, req_regbank clear, and owning no port.
REQ-018 SHALL, on a grant, register the owner, enter BUSY next cycle, pulse pipeline_granted[winner] for exactly that cycle, and set rr[p] to winner+1, wrapping at NUM_BUFFERS.
REQ-019 SHALL have grant latency 0: pipeline_granted is combinational from the current-cycle request, and ownership is registered.
REQ-020 SHALL make no grant and leave rr[p] unchanged while p is FREE and outport_ready[p] is low.
REQ-021 SHALL, in BUSY, on pkt_done[owner], return to FREE next cycle with owner cleared; p is regrantable no earlier than the following cycle (one bubble).
REQ-022 SHALL ignore pkt_done from a buffer that owns no port.
REQ-023 SHALL keep a per-port stall counter of clog2(STALL_LIMIT+1) bits, cleared on grant or when outport_ready[p] is high, incremented while BUSY and outport_ready[p] is low, and saturating.
REQ-024 SHALL, when the stall counter reaches STALL_LIMIT, pulse pipeline_failed[owner] and return p to FREE next cycle.
REQ-025 SHALL give pkt_done priority over stall teardown in the same cycle, so pipeline_failed does not pulse.
REQ-026 SHALL arbitrate the single shared register bank round-robin each cycle among req_regbank, grant at most one buffer per cycle, and advance its pointer past the winner.
REQ-027 SHALL treat req_regbank with req_pipeline on the same buffer as a register bank request only.
REQ-028 SHALL guarantee that no buffer owns two ports, no port has two owners, and each output is at most one-hot per cycle.

Reset
REQ-029 SHALL, while nRST is low, put all ports in FREE, clear owners, clear stall counters, set all round-robin pointers to 0, and drive all outputs to 0; this also applies mid-packet.

Verification
REQ-030 SHALL cover contention: buffers 0, 1 and 2 request port 1 with ready high -> grants go to 0, then 1, then 2, each one cycle after the prior pkt_done plus one bubble.
REQ-031 SHALL cover not-ready: buffer 3 requests port 0 with outport_ready[0] low for 5 cycles -> no grant; grant comes in the first cycle ready is high.
REQ-032 SHALL cover stall: with STALL_LIMIT=16, port 2 owned and ready low for 16 cycles -> pipeline_failed[owner] pulses once, and outport_busy[2] is 0 the next cycle.
REQ-033 SHALL cover the tie: pkt_done and the stall limit reached in the same cycle -> no pipeline_failed pulse, and the port is freed.
REQ-034 SHALL cover register bank fairness: buffers 0 and 2 hold req_regbank -> reg_bank_granted alternates 0, 2, 0, with no pipeline_granted.
REQ-035 SHALL cover mid-packet reset: nRST asserted while 2 ports are busy -> all outputs are 0 at once, and after release the first grant goes to the lowest-index requester.
